// File: rtl/ibex_bist_pkg.sv
// Shared types and constants for the ibex ALU runtime-BIST scheduler.
package ibex_bist_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IVL = 2'd1,
    ARMED    = 2'd2,
    RUN      = 2'd3
  } bist_sched_state_e;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Every bit of p + ~p is one, so a healthy adder returns all ones.
  localparam logic BIST_EXPECT_ADD = 1'b1;

  function automatic logic [7:0] effective_thresh(input logic [7:0] thresh);
    return (thresh == 8'd0) ? 8'd1 : thresh;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR pattern source for ALU BIST: reloads SEED on load_i, steps on advance_i.
module bist_lfsr
  import ibex_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hACE1_2468)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_next;

  always_comb begin
    state_next = state_q >> 1;
    if (state_q[0]) begin
      state_next = state_next ^ TAPS;
    end
  end

  // A session restart takes priority over stepping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= SEED;
    end else if (advance_i) begin
      state_q <= state_next;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ibex_alu_bist_scheduler.sv
// Lends the shared ibex ALU to runtime BIST during idle windows; the core always wins the ALU back.
module ibex_alu_bist_scheduler
  import ibex_bist_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           NUM_PATTERNS = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED    = DATA_WIDTH'(32'hACE1_2468),
  parameter int unsigned           CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  core_req_i,
  input  logic [CNT_W-1:0]      interval_i,
  input  logic [7:0]            idle_thresh_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  output logic                  bist_active_o,
  output logic [DATA_WIDTH-1:0] pattern_o,
  output logic                  session_done_o,
  output logic                  fail_o,
  input  logic                  err_clr_i,
  output logic                  error_irq_o,
  output logic [CNT_W-1:0]      pass_cnt_o,
  output logic [CNT_W-1:0]      abort_cnt_o
);

  localparam int unsigned           PAT_W         = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [PAT_W-1:0]      LAST_PAT      = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [DATA_WIDTH-1:0] EXPECT_RESULT = {DATA_WIDTH{BIST_EXPECT_ADD}};
  localparam logic [CNT_W-1:0]      CNT_MAX       = {CNT_W{1'b1}};

  bist_sched_state_e state_q, state_d;

  logic [CNT_W-1:0] ivl_cnt_q;
  logic [7:0]       idle_cnt_q;
  logic [7:0]       thresh_eff;
  logic             idle_hit;
  logic [PAT_W-1:0] pat_idx_q;
  logic             sess_err_q;
  logic             fail_q;
  logic             session_done_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] abort_cnt_q;

  logic             mismatch;
  logic             sess_end;
  logic             preempt;
  logic             lfsr_load;

  // The current idle cycle counts toward the window, so RUN follows the thresh-th idle cycle.
  assign thresh_eff = effective_thresh(idle_thresh_i);
  assign idle_hit   = !core_req_i && (({1'b0, idle_cnt_q} + 9'd1) >= {1'b0, thresh_eff});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     state_d = WAIT_IVL;
        WAIT_IVL: if (ivl_cnt_q == '0) state_d = ARMED;
        ARMED:    if (idle_hit) state_d = RUN;
        RUN: begin
          if (core_req_i) begin
            state_d = ARMED;
          end else if (pat_idx_q == LAST_PAT) begin
            state_d = WAIT_IVL;
          end
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // The ALU is only borrowed on cycles the core leaves free; a core request drops it combinationally.
  always_comb begin
    bist_active_o = 1'b0;
    mismatch      = 1'b0;
    sess_end      = 1'b0;
    preempt       = 1'b0;
    if (state_q == RUN && enable_i) begin
      bist_active_o = ~core_req_i;
      preempt       = core_req_i;
      mismatch      = ~core_req_i && (result_i != EXPECT_RESULT);
      sess_end      = ~core_req_i && (pat_idx_q == LAST_PAT);
    end
  end

  assign lfsr_load = (state_q == ARMED) && (state_d == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ivl_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      pat_idx_q      <= '0;
      sess_err_q     <= 1'b0;
      fail_q         <= 1'b0;
      session_done_q <= 1'b0;
      pass_cnt_q     <= '0;
      abort_cnt_q    <= '0;
    end else begin
      if (state_q == IDLE || sess_end) begin
        ivl_cnt_q <= interval_i;
      end else if (state_q == WAIT_IVL && ivl_cnt_q != '0) begin
        ivl_cnt_q <= ivl_cnt_q - CNT_W'(1);
      end

      if (state_q != ARMED || core_req_i) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 8'd1;
      end

      if (state_q == ARMED) begin
        pat_idx_q  <= '0;
        sess_err_q <= 1'b0;
      end else if (bist_active_o) begin
        pat_idx_q <= pat_idx_q + PAT_W'(1);
        if (mismatch) begin
          sess_err_q <= 1'b1;
        end
      end

      // A fresh mismatch outranks a simultaneous clear.
      if (mismatch) begin
        fail_q <= 1'b1;
      end else if (err_clr_i) begin
        fail_q <= 1'b0;
      end

      session_done_q <= sess_end;

      if (sess_end && !sess_err_q && !mismatch && pass_cnt_q != CNT_MAX) begin
        pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      end

      if (preempt && abort_cnt_q != CNT_MAX) begin
        abort_cnt_q <= abort_cnt_q + CNT_W'(1);
      end
    end
  end

  bist_lfsr #(
    .WIDTH (DATA_WIDTH),
    .TAPS  (DATA_WIDTH'(LFSR_TAPS)),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (lfsr_load),
    .advance_i (bist_active_o),
    .state_o   (pattern_o)
  );

  assign session_done_o = session_done_q;
  assign fail_o         = fail_q;
  assign error_irq_o    = fail_q;
  assign pass_cnt_o     = pass_cnt_q;
  assign abort_cnt_o    = abort_cnt_q;

endmodule

// File: tb/tb_ibex_alu_bist_scheduler.sv
// Directed bench for the ALU BIST scheduler: cycle table for sessions/preempt, hand sequences for corners.
module tb_ibex_alu_bist_scheduler;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable, core_req, err_clr;
  logic [15:0] interval;
  logic [7:0]  thresh;
  logic [31:0] result, corrupt, pattern;
  logic        bist_active, session_done, fail, error_irq;
  logic [15:0] pass_cnt, abort_cnt;

  logic        enable_s, core_req_s, err_clr_s;
  logic [3:0]  interval_s;
  logic [7:0]  thresh_s;
  logic [31:0] result_s, pattern_s;
  logic        active_s, done_s, fail_s, irq_s;
  logic [3:0]  pass_s, abort_s;

  // ALU model: p + ~p is all ones; corrupt injects a faulty result bit.
  assign result   = (pattern + ~pattern) ^ corrupt;
  assign result_s = pattern_s + ~pattern_s;

  ibex_alu_bist_scheduler dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .core_req_i     (core_req),
    .interval_i     (interval),
    .idle_thresh_i  (thresh),
    .result_i       (result),
    .bist_active_o  (bist_active),
    .pattern_o      (pattern),
    .session_done_o (session_done),
    .fail_o         (fail),
    .err_clr_i      (err_clr),
    .error_irq_o    (error_irq),
    .pass_cnt_o     (pass_cnt),
    .abort_cnt_o    (abort_cnt)
  );

  ibex_alu_bist_scheduler #(.CNT_W(4)) dut_sat (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable_s),
    .core_req_i     (core_req_s),
    .interval_i     (interval_s),
    .idle_thresh_i  (thresh_s),
    .result_i       (result_s),
    .bist_active_o  (active_s),
    .pattern_o      (pattern_s),
    .session_done_o (done_s),
    .fail_o         (fail_s),
    .err_clr_i      (err_clr_s),
    .error_irq_o    (irq_s),
    .pass_cnt_o     (pass_s),
    .abort_cnt_o    (abort_s)
  );

  typedef struct {
    logic        core_req;
    logic        exp_active;
    logic        exp_done;
    logic [31:0] exp_pass;
    logic [31:0] exp_abort;
    logic        chk_pat;
    logic [31:0] exp_pat;
  } vec_t;

  vec_t        vecs[43];
  logic [31:0] pats[5];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic [31:0] corr, input logic clr);
    core_req = cr;
    corrupt  = corr;
    err_clr  = clr;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;

    rst_n = 1'b0; enable = 1'b0; core_req = 1'b0; err_clr = 1'b0;
    interval = 16'd4; thresh = 8'd3; corrupt = '0;
    enable_s = 1'b0; core_req_s = 1'b0; err_clr_s = 1'b0;
    interval_s = 4'd0; thresh_s = 8'd1;

    // Hand-computed Galois steps from the seed.
    pats[0] = 32'hACE1_2468; pats[1] = 32'h5670_9234; pats[2] = 32'h2B38_491A;
    pats[3] = 32'h159C_248D; pats[4] = 32'h8AEE_1245;

    // T1/T2 cycle table: cycle 0 is the first cycle with enable high.
    for (int c = 0; c < 43; c++)
      vecs[c] = '{core_req: 1'b0, exp_active: 1'b0, exp_done: 1'b0, exp_pass: 32'd0,
                  exp_abort: 32'd0, chk_pat: 1'b0, exp_pat: 32'd0};
    for (int c = 9; c <= 24; c++) vecs[c].exp_active = 1'b1;
    vecs[25].exp_done = 1'b1;
    for (int c = 25; c < 43; c++) vecs[c].exp_pass = 32'd1;
    for (int c = 33; c <= 37; c++) vecs[c].exp_active = 1'b1;
    vecs[38].core_req = 1'b1;
    for (int c = 39; c < 43; c++) vecs[c].exp_abort = 32'd1;
    vecs[42].exp_active = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vecs[9 + k].chk_pat  = 1'b1; vecs[9 + k].exp_pat  = pats[k];
      vecs[33 + k].chk_pat = 1'b1; vecs[33 + k].exp_pat = pats[k];
    end
    vecs[42].chk_pat = 1'b1; vecs[42].exp_pat = pats[0];

    #12;
    checkOutput("reset active", 32'(bist_active), 32'd0);
    checkOutput("reset done", 32'(session_done), 32'd0);
    checkOutput("reset fail", 32'(fail), 32'd0);
    checkOutput("reset irq", 32'(error_irq), 32'd0);
    checkOutput("reset pass", 32'(pass_cnt), 32'd0);
    checkOutput("reset abort", 32'(abort_cnt), 32'd0);
    checkOutput("reset pattern", pattern, SEED);

    next_edge();
    rst_n = 1'b1;
    enable = 1'b1;

    for (int c = 0; c < 43; c++) begin
      applyStimulus(vecs[c].core_req, 32'd0, 1'b0);
      checkOutput($sformatf("t1 c%0d active", c), 32'(bist_active), 32'(vecs[c].exp_active));
      checkOutput($sformatf("t1 c%0d done", c), 32'(session_done), 32'(vecs[c].exp_done));
      checkOutput($sformatf("t1 c%0d pass", c), 32'(pass_cnt), vecs[c].exp_pass);
      checkOutput($sformatf("t1 c%0d abort", c), 32'(abort_cnt), vecs[c].exp_abort);
      checkOutput($sformatf("t1 c%0d fail", c), 32'(fail), 32'd0);
      if (vecs[c].chk_pat)
        checkOutput($sformatf("t1 c%0d pattern", c), pattern, vecs[c].exp_pat);
      next_edge();
    end

    // T3: session from cycle 42 hits pattern 7 at cycle 49; clear asserted in the same cycle.
    for (int c = 43; c <= 60; c++) begin
      applyStimulus(1'b0, (c == 49) ? 32'd1 : 32'd0, (c == 49 || c == 59));
      checkOutput($sformatf("t3 c%0d active", c), 32'(bist_active), 32'(c <= 57));
      if (c == 49) checkOutput("t3 fail before edge", 32'(fail), 32'd0);
      if (c == 50) begin
        checkOutput("t3 fail set", 32'(fail), 32'd1);
        checkOutput("t3 irq set", 32'(error_irq), 32'd1);
      end
      if (c == 58) begin
        checkOutput("t3 done", 32'(session_done), 32'd1);
        checkOutput("t3 pass unchanged", 32'(pass_cnt), 32'd1);
        checkOutput("t3 fail sticky", 32'(fail), 32'd1);
      end
      if (c == 60) begin
        checkOutput("t3 fail cleared", 32'(fail), 32'd0);
        checkOutput("t3 irq cleared", 32'(error_irq), 32'd0);
      end
      next_edge();
    end
    applyStimulus(1'b0, 32'd0, 1'b0);

    // T4: reach the next RUN (bounded), then assert reset between edges.
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (bist_active) seen = 1'b1;
      else begin
        next_edge();
        @(negedge clk);
      end
    end
    checkOutput("t4 reached run", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t4 async active", 32'(bist_active), 32'd0);
    checkOutput("t4 async pattern", pattern, SEED);
    checkOutput("t4 async pass", 32'(pass_cnt), 32'd0);
    checkOutput("t4 async abort", 32'(abort_cnt), 32'd0);
    checkOutput("t4 async done", 32'(session_done), 32'd0);
    next_edge();
    enable = 1'b1; interval = 16'd0; thresh = 8'd0;
    rst_n = 1'b1;

    // T5: interval 0, thresh 0 -> RUN at cycle 3, next session at cycle 21; disable at 22.
    for (int c = 0; c <= 23; c++) begin
      enable = (c < 22);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput($sformatf("t5 c%0d active", c), 32'(bist_active),
                  32'((c >= 3 && c <= 18) || c == 21));
      checkOutput($sformatf("t5 c%0d done", c), 32'(session_done), 32'(c == 19));
      checkOutput($sformatf("t5 c%0d pass", c), 32'(pass_cnt), 32'(c >= 19));
      checkOutput($sformatf("t5 c%0d abort", c), 32'(abort_cnt), 32'd0);
      if (c == 3 || c == 21)
        checkOutput($sformatf("t5 c%0d pattern", c), pattern, SEED);
      next_edge();
    end

    // T6: abort on every RUN cycle of the 4-bit instance; 20 aborts saturate at 4'hF.
    enable_s = 1'b1;
    for (int c = 0; c <= 42; c++) begin
      core_req_s = (c >= 3 && (c % 2) == 1);
      @(negedge clk);
      if (core_req_s) checkOutput($sformatf("t6 c%0d active", c), 32'(active_s), 32'd0);
      if (c == 22) checkOutput("t6 ten aborts", 32'(abort_s), 32'd10);
      next_edge();
    end
    core_req_s = 1'b0;
    @(negedge clk);
    checkOutput("t6 abort saturated", 32'(abort_s), 32'hF);
    checkOutput("t6 pass", 32'(pass_s), 32'd0);
    checkOutput("t6 done", 32'(done_s), 32'd0);
    checkOutput("t6 fail", 32'(fail_s), 32'd0);
    checkOutput("t6 irq", 32'(irq_s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
